// File: rtl/threshold_sequencer.sv
// Frame-synchronous enable/threshold controller for the delayed-gray thresholder: frame mean via serial divide.
// Latency: iFrameEnd to oMeanValid is CNT_W+8+1 cycles; enable/threshold change one cycle after iFrameStart.
// No backpressure: a frame end that arrives while dividing is dropped and flagged on sticky oOverrun.
// Optional: define THRESH_SEQ_SMOOTH_EN to IIR-smooth the auto threshold (average of old and new, round half up).
`timescale 1ns/1ps

module threshold_sequencer #(
  parameter int         CNT_W          = 20,
  parameter logic [7:0] DEFAULT_THRESH = 8'd128
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSwEnable,
  input  logic       iAuto,
  input  logic [7:0] iManualThreshold,
  input  logic [7:0] iOffset,
  input  logic [7:0] iGray,
  input  logic       iGrayValid,
  input  logic       iFrameStart,
  input  logic       iFrameEnd,
  output logic       oEnable,
  output logic [7:0] oThreshold,
  output logic [7:0] oMean,
  output logic       oMeanValid,
  output logic       oBusy,
  output logic       oOverrun
);

  // Sum width covers a full-count frame of 255-valued pixels without overflow.
  localparam int SUM_W  = CNT_W + 8;
  localparam int STEP_W = $clog2(SUM_W + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ---------------------------------------------------------------------------
  // Pixel accumulation
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take_pix;
  logic [SUM_W-1:0] sum_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic [SUM_W-1:0] snap_sum;
  logic [CNT_W-1:0] snap_cnt;

  // Once the counter saturates both sum and count freeze so the mean stays sane.
  assign take_pix = iGrayValid && (cnt_q != CNT_MAX);
  assign sum_inc  = sum_q + SUM_W'(iGray);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // The snapshot includes a pixel that arrives in the frame-end cycle itself.
  assign snap_sum = take_pix ? sum_inc : sum_q;
  assign snap_cnt = take_pix ? cnt_inc : cnt_q;

  // Accumulator next state: clear at frame end, otherwise add valid pixels.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (iFrameEnd) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (take_pix) begin
      sum_d = sum_inc;
      cnt_d = cnt_inc;
    end
  end

  // Accumulator registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and restoring divider
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [SUM_W-1:0]  dvd_q, dvd_d;   // dividend, shifted out MSB first
  logic [CNT_W-1:0]  dvs_q, dvs_d;   // divisor (pixel count)
  logic [CNT_W-1:0]  rem_q, rem_d;   // partial remainder, always < divisor
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic              accept;
  logic              last_step;
  logic [CNT_W:0]    rem_sh;
  logic              rem_ge;
  logic [SUM_W-1:0]  quo_nx;
  logic [7:0]        quo_sat;

  // A new frame is only taken when the divider is free and the frame had pixels;
  // the DONE cycle is free, so back-to-back frames are not falsely dropped.
  assign accept    = iFrameEnd && (state_q != S_DIV) && (snap_cnt != '0);
  assign last_step = (step_q == LAST_STEP);

  // One restoring-division step: bring down the next dividend bit, trial subtract.
  assign rem_sh  = {rem_q, dvd_q[SUM_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs_q});
  assign quo_nx  = (quo_q << 1) | SUM_W'(rem_ge);
  assign quo_sat = (|(quo_nx >> 8)) ? 8'hFF : quo_nx[7:0];

  // FSM next state: IDLE -> DIV for SUM_W steps -> DONE for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_DIV;
      S_DIV:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_DIV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider datapath next state: load on accept, otherwise step while dividing.
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    step_d = step_q;
    if (accept) begin
      dvd_d  = snap_sum;
      dvs_d  = snap_cnt;
      rem_d  = '0;
      quo_d  = '0;
      step_d = '0;
    end else if (state_q == S_DIV) begin
      dvd_d  = dvd_q << 1;
      rem_d  = CNT_W'(rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh);
      quo_d  = quo_nx;
      step_d = step_q + STEP_W'(1);
    end
  end

  // FSM and divider registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mean, overrun and pending auto threshold
  // ---------------------------------------------------------------------------
  logic [7:0]        mean_q, mean_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        pend_q, pend_d;
  logic signed [9:0] mean_off;
  logic [7:0]        clamp_res;
  logic [7:0]        pend_new;

  // mean + signed offset spans -128..382, so a 10-bit signed sum never wraps.
  assign mean_off  = $signed({2'b00, mean_q}) + $signed({{2{iOffset[7]}}, iOffset});
  assign clamp_res = mean_off[9] ? 8'd0 : (mean_off[8] ? 8'hFF : mean_off[7:0]);

`ifdef THRESH_SEQ_SMOOTH_EN
  // Average of previous and new target, rounding half up; 255+255+1 fits 9 bits.
  assign pend_new = 8'(({1'b0, pend_q} + {1'b0, clamp_res} + 9'd1) >> 1);
`else
  assign pend_new = clamp_res;
`endif

  // Mean is written on the final divide step so it is valid throughout DONE;
  // the pending threshold is derived from it during DONE.
  always_comb begin
    mean_d = mean_q;
    ovr_d  = ovr_q;
    pend_d = pend_q;
    if ((state_q == S_DIV) && last_step) mean_d = quo_sat;
    if (iFrameEnd && (state_q == S_DIV)) ovr_d = 1'b1;
    if (state_q == S_DONE) pend_d = pend_new;
  end

  // Mean, overrun and pending threshold registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mean_q <= '0;
      ovr_q  <= 1'b0;
      pend_q <= DEFAULT_THRESH;
    end else begin
      mean_q <= mean_d;
      ovr_q  <= ovr_d;
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-aligned apply
  // ---------------------------------------------------------------------------
  logic       en_q, en_d;
  logic [7:0] thr_q, thr_d;

  // Outputs only move at frame start; a DONE in the same cycle still sees the
  // old pending value, so the new one waits for the following frame.
  always_comb begin
    en_d  = en_q;
    thr_d = thr_q;
    if (iFrameStart) begin
      en_d  = iSwEnable;
      thr_d = iAuto ? pend_q : iManualThreshold;
    end
  end

  // Applied enable/threshold registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      en_q  <= 1'b0;
      thr_q <= DEFAULT_THRESH;
    end else begin
      en_q  <= en_d;
      thr_q <= thr_d;
    end
  end

  assign oEnable    = en_q;
  assign oThreshold = thr_q;
  assign oMean      = mean_q;
  assign oMeanValid = (state_q == S_DONE);
  assign oBusy      = (state_q == S_DIV);
  assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_threshold_sequencer.sv
// Directed bench for threshold_sequencer: frame-level model plus literal expectations.
`timescale 1ns/1ps

module tb_threshold_sequencer;

  localparam int DIV_CYC = 28;            // CNT_W + 8 at default CNT_W
  localparam int CNT_MAX = (1 << 20) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_en = 1'b0;
  logic       auto_m = 1'b0;
  logic [7:0] manual = 8'd0;
  logic [7:0] offset = 8'd0;
  logic [7:0] gray = 8'd0;
  logic       gv = 1'b0;
  logic       fs = 1'b0;
  logic       fe = 1'b0;

  logic       o_en;
  logic [7:0] o_thr;
  logic [7:0] o_mean;
  logic       o_mv;
  logic       o_busy;
  logic       o_ovr;

  always #5 clk = ~clk;

  threshold_sequencer dut (
    .iCLK             (clk),
    .iRST_N           (rst_n),
    .iSwEnable        (sw_en),
    .iAuto            (auto_m),
    .iManualThreshold (manual),
    .iOffset          (offset),
    .iGray            (gray),
    .iGrayValid       (gv),
    .iFrameStart      (fs),
    .iFrameEnd        (fe),
    .oEnable          (o_en),
    .oThreshold       (o_thr),
    .oMean            (o_mean),
    .oMeanValid       (o_mv),
    .oBusy            (o_busy),
    .oOverrun         (o_ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int m_sum = 0, m_cnt = 0;
  int m_en = 0, m_thr = 128, m_pend = 128;
  int m_mean = 0, m_mv = 0, m_ovr = 0;
  int m_left = 0, m_q = 0;
  int s_snap, c_snap;
  bit was_busy;

  function automatic int clamp255(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int next_pend(input int prev, input int mean, input int off);
    int c;
    c = clamp255(mean + off);
`ifdef THRESH_SEQ_SMOOTH_EN
    return (prev + c + 1) / 2;
`else
    return c + 0 * prev;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_en = 0; m_thr = 128; m_pend = 128;
      m_mean = 0; m_mv = 0; m_ovr = 0; m_left = 0; m_q = 0;
    end else begin
      was_busy = (m_left > 0);
      if (fs) begin
        m_en  = int'(sw_en);
        m_thr = auto_m ? m_pend : int'(manual);
      end
      if (m_mv == 1) begin
        m_pend = next_pend(m_pend, m_mean, int'($signed(offset)));
        m_mv = 0;
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_mean = (m_q > 255) ? 255 : m_q;
          m_mv = 1;
        end
      end
      if (fe) begin
        s_snap = m_sum;
        c_snap = m_cnt;
        if (gv && m_cnt < CNT_MAX) begin
          s_snap += int'(gray);
          c_snap++;
        end
        if (was_busy) m_ovr = 1;
        else if (c_snap > 0) begin
          m_left = DIV_CYC;
          m_q = s_snap / c_snap;
        end
        m_sum = 0;
        m_cnt = 0;
      end else if (gv && m_cnt < CNT_MAX) begin
        m_sum += int'(gray);
        m_cnt++;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("enable",    int'(o_en),   m_en);
    chk("threshold", int'(o_thr),  m_thr);
    chk("mean",      int'(o_mean), m_mean);
    chk("mean_vld",  int'(o_mv),   m_mv);
    chk("busy",      int'(o_busy), (m_left > 0) ? 1 : 0);
    chk("overrun",   int'(o_ovr),  m_ovr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      gv = 1'b1;
      gray = 8'(v);
      tick();
    end
    gv = 1'b0;
  endtask

  task automatic fend();
    fe = 1'b1;
    tick();
    fe = 1'b0;
  endtask

  task automatic fstart();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  // Returns at the negedge of the cycle where oMeanValid is high.
  task automatic wait_mean(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 80) begin
      lat++;
      @(negedge clk);
      if (o_mv) got = 1'b1;
      else tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL mean_timeout actual=no_pulse required=pulse at %0t", $time);
    end
  endtask

  // Hand-computed expectations (smoothing starts from 128 after reset).
`ifdef THRESH_SEQ_SMOOTH_EN
  localparam int E2 = 114, E3A = 185, E3B = 93, E6A = 114, E6 = 158;
`else
  localparam int E2 = 100, E3A = 255, E3B = 0, E6A = 100, E6 = 201;
`endif

  int lat;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_thr", int'(o_thr), 128);
    chk("rst_en", int'(o_en), 0);
    chk("rst_mean", int'(o_mean), 0);
    rst_n = 1'b1;
    tick();

    // 1: manual apply and hold between frame starts
    sw_en = 1'b1; auto_m = 1'b0; manual = 8'd50;
    fstart();
    chk("t1_en", int'(o_en), 1);
    chk("t1_thr", int'(o_thr), 50);
    manual = 8'd77; sw_en = 1'b0;
    repeat (3) tick();
    chk("t1_hold_thr", int'(o_thr), 50);
    chk("t1_hold_en", int'(o_en), 1);

    // 2: auto, offset 0, 16 pixels of 100
    sw_en = 1'b1; auto_m = 1'b1; offset = 8'd0;
    pixels(16, 100);
    fend();
    wait_mean(lat);
    chk("t2_latency", lat, 29);
    chk("t2_mean", int'(o_mean), 100);
    tick();
    fstart();
    chk("t2_thr", int'(o_thr), E2);

    // 3a: mean 250 + 20 clamps high; last pixel rides on the frame-end cycle
    offset = 8'd20;
    pixels(3, 250);
    gv = 1'b1; gray = 8'd250;
    fend();
    gv = 1'b0;
    wait_mean(lat);
    chk("t3a_mean", int'(o_mean), 250);
    tick();
    fstart();
    chk("t3a_thr", int'(o_thr), E3A);

    // 3b: mean 10 - 30 clamps low
    offset = 8'hE2;
    pixels(3, 10);
    fend();
    wait_mean(lat);
    chk("t3b_mean", int'(o_mean), 10);
    tick();
    fstart();
    chk("t3b_thr", int'(o_thr), E3B);

    // 4: zero-pixel frame starts nothing
    fend();
    chk("t4_busy", int'(o_busy), 0);
    repeat (35) tick();
    fstart();
    chk("t4_thr", int'(o_thr), E3B);

    // 5: overrun, then reset in the middle of a divide
    offset = 8'd0;
    pixels(8, 60);
    fend();
    pixels(4, 200);
    fend();
    chk("t5_ovr", int'(o_ovr), 1);
    wait_mean(lat);
    chk("t5_mean", int'(o_mean), 60);
    chk("t5_ovr_sticky", int'(o_ovr), 1);
    tick();
    pixels(4, 90);
    fend();
    repeat (10) tick();
    chk("t5_busy_mid", int'(o_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", int'(o_busy), 0);
    chk("t5_rst_ovr", int'(o_ovr), 0);
    chk("t5_rst_thr", int'(o_thr), 128);
    chk("t5_rst_en", int'(o_en), 0);
    chk("t5_rst_mean", int'(o_mean), 0);
    chk("t5_rst_mv", int'(o_mv), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 6: DONE coinciding with frame start, start+end together, smoothing check
    sw_en = 1'b1; auto_m = 1'b1; offset = 8'd0;
    pixels(5, 100);
    fend();
    wait_mean(lat);
    fs = 1'b1;
    @(posedge clk);
    #1;
    fs = 1'b0;
    chk("t6_done_fs_thr", int'(o_thr), 128);
    pixels(5, 201);
    fs = 1'b1; fe = 1'b1;
    tick();
    fs = 1'b0; fe = 1'b0;
    chk("t6_fs_fe_thr", int'(o_thr), E6A);
    wait_mean(lat);
    chk("t6_mean", int'(o_mean), 201);
    tick();
    fstart();
    chk("t6_thr", int'(o_thr), E6);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
